// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared types and constants for the branch resolve unit
package branch_resolve_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
  typedef enum logic {RUN, FLUSH} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } entry_t;
endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// branch_resolve_unit_pred_queue: in-order prediction FIFO with clear, empty bypass and error strobes
module branch_resolve_unit_pred_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   avail,
  output logic   empty,
  output logic   full,
  output logic   err_ovf,
  output logic   err_unf
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  always_comb begin
    empty   = wp == rp;
    full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // empty push+pop passes the incoming entry straight through
    we      = push && !(empty && pop) && (!full || pop);
    re      = pop && !empty;
    dout    = empty ? din : mem[rp[AW-1:0]];
    avail   = !empty || push;
    err_ovf = push && full && !pop && !clear;
    err_unf = pop && empty && !push;
  end
  always_ff @(posedge clk)
    if (we) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(we);
      rp <= rp + (AW+1)'(re);
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks fetch-time predictions against EX outcomes, redirects and flushes on mispredict
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clkFSM,
  input  logic             reset,
  input  logic             fetch_br,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             ex_br,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  output logic             result,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count,
  output logic             err_overflow,
  output logic             err_underflow
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  state_t state;
  logic [FW-1:0] fcnt;
  entry_t head;
  logic run, push, pop, avail, resolve, mis, empty, full, ovf, unf;
  always_comb begin
    run     = state == RUN;
    push    = fetch_br && run;
    pop     = ex_br && run;
    resolve = pop && avail;
    mis     = resolve && ((ex_taken != head.pred_taken) || (ex_taken && ex_target != head.pred_target));
  end
  branch_resolve_unit_pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clkFSM),
    .rst_n(reset),
    .clear(mis),
    .push(push),
    .pop(pop),
    .din('{pc: fetch_pc, pred_taken: pred_taken, pred_target: pred_target}),
    .dout(head),
    .avail(avail),
    .empty(empty),
    .full(full),
    .err_ovf(ovf),
    .err_unf(unf)
  );
  always_ff @(posedge clkFSM or negedge reset)
    if (!reset) begin
      state          <= RUN;
      fcnt           <= '0;
      result         <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      br_count       <= '0;
      mispred_count  <= '0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      redirect_valid <= mis;
      err_overflow   <= err_overflow | ovf;
      err_underflow  <= err_underflow | unf;
      if (resolve) begin
        result   <= ex_taken;
        br_count <= br_count + CNT_W'(br_count != '1);
      end
      if (mis) begin
        mispred_count <= mispred_count + CNT_W'(mispred_count != '1);
        redirect_pc   <= ex_taken ? ex_target : head.pc + PC_INC;
        state         <= FLUSH;
        fcnt          <= FW'(FLUSH_CYCLES - 1);
        flush         <= 1'b1;
      end else if (state == FLUSH) begin
        if (fcnt == '0) begin
          state <= RUN;
          flush <= 1'b0;
        end else fcnt <= fcnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with hand-computed expectations for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clkFSM = 0, reset = 0;
  logic fetch_br = 0, pred_taken = 0, ex_br = 0, ex_taken = 0;
  logic [31:0] fetch_pc = 0, pred_target = 0, ex_target = 0;
  logic result, redirect_valid, flush, err_overflow, err_underflow;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mispred_count;
  int vectors = 0, miscompares = 0;
  branch_resolve_unit dut (
    .clkFSM(clkFSM), .reset(reset), .fetch_br(fetch_br), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .ex_br(ex_br), .ex_taken(ex_taken),
    .ex_target(ex_target), .result(result), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .br_count(br_count), .mispred_count(mispred_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );
  always #5 clkFSM = ~clkFSM;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clkFSM);
    #1;
  endtask
  task automatic idle();
    fetch_br = 0;
    ex_br = 0;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    fetch_br = 1;
    fetch_pc = pc;
    pred_taken = pt;
    pred_target = tgt;
  endtask
  task automatic resolve(input logic t, input logic [31:0] tgt);
    ex_br = 1;
    ex_taken = t;
    ex_target = tgt;
  endtask
  initial begin
    repeat (2) step();
    chk("rst_result", result, 1);
    chk("rst_flush", flush, 0);
    chk("rst_br", br_count, 0);
    chk("rst_mis", mispred_count, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_err", {err_overflow, err_underflow}, 0);
    #3 reset = 1;
    repeat (3) step();
    chk("idle_result", result, 1);
    chk("idle_redir", redirect_valid, 0);
    chk("idle_br", br_count, 0);
    // correctly predicted taken branch
    fetch(32'h100, 1, 32'h200); step();
    idle(); resolve(1, 32'h200); step();
    idle();
    chk("ok_br", br_count, 1);
    chk("ok_redir", redirect_valid, 0);
    chk("ok_result", result, 1);
    chk("ok_flush", flush, 0);
    // predicted taken, actually not taken
    fetch(32'h100, 1, 32'h200); step();
    idle(); resolve(0, 32'h0); step();
    idle();
    chk("nt_redir", redirect_valid, 1);
    chk("nt_rpc", redirect_pc, 32'h104);
    chk("nt_flush1", flush, 1);
    chk("nt_mis", mispred_count, 1);
    chk("nt_br", br_count, 2);
    chk("nt_result", result, 0);
    step();
    chk("nt_pulse", redirect_valid, 0);
    chk("nt_flush2", flush, 1);
    step();
    chk("nt_flush3", flush, 0);
    // target mismatch with wrong-path younger entries
    fetch(32'h400, 1, 32'h200); step();
    fetch(32'h500, 0, 32'h0); step();
    fetch(32'h600, 0, 32'h0); step();
    idle(); resolve(1, 32'h300); step();
    idle();
    chk("tg_rpc", redirect_pc, 32'h300);
    chk("tg_redir", redirect_valid, 1);
    chk("tg_mis", mispred_count, 2);
    chk("tg_br", br_count, 3);
    chk("tg_result", result, 1);
    fetch(32'h900, 0, 32'h0); step();
    step();
    idle();
    chk("tg_flush_end", flush, 0);
    chk("tg_unf_pre", err_underflow, 0);
    resolve(0, 32'h0); step();
    idle();
    chk("tg_unf", err_underflow, 1);
    chk("tg_unf_br", br_count, 3);
    // fill past capacity
    for (int i = 0; i < 5; i++) begin
      fetch(32'h1000 + i * 16, 0, 32'h0); step();
      if (i == 3) chk("ovf_pre", err_overflow, 0);
    end
    idle();
    chk("ovf", err_overflow, 1);
    for (int i = 0; i < 5; i++) begin
      resolve(0, 32'h0); step();
    end
    idle();
    chk("ovf_kept", br_count, 7);
    chk("ovf_mis", mispred_count, 2);
    // bypass on empty queue
    fetch(32'h700, 1, 32'h780); resolve(1, 32'h780); step();
    idle();
    chk("byp_ok_br", br_count, 8);
    chk("byp_ok_mis", mispred_count, 2);
    chk("byp_ok_redir", redirect_valid, 0);
    fetch(32'h800, 1, 32'h880); resolve(0, 32'h0); step();
    idle();
    chk("byp_mis", mispred_count, 3);
    chk("byp_rpc", redirect_pc, 32'h804);
    chk("byp_flush", flush, 1);
    chk("byp_result", result, 0);
    // asynchronous reset in the middle of the flush window
    #2 reset = 0;
    #1;
    chk("ar_flush", flush, 0);
    chk("ar_br", br_count, 0);
    chk("ar_mis", mispred_count, 0);
    chk("ar_redir", redirect_valid, 0);
    chk("ar_result", result, 1);
    chk("ar_err", {err_overflow, err_underflow}, 0);
    step();
    #3 reset = 1;
    repeat (3) begin
      step();
      chk("ar_post_redir", redirect_valid, 0);
      chk("ar_post_flush", flush, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
